// File: rtl/mxu_sequencer.sv
// mxu_sequencer: drives one mxu_wrapper job through setup/stream/flush/drain and pulses done.
// Optional busy/stall performance counters are enabled by defining MXU_SEQ_PERF_CNT_EN.
`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 2
`endif
module mxu_sequencer #(
  parameter int M = 4,
  parameter int K = 4,
  parameter int MAX_VECTORS = 256,
  localparam int CW = $clog2(MAX_VECTORS + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               ready,
  input  logic [`LOG_ALLOWED_PRECISIONS-1:0] cfg_data_type,
  input  logic [1:0]                         cfg_fp_unit,
  input  logic [CW-1:0]                      cfg_n_vectors,
  input  logic                               cfg_test_mode,
  input  logic                               abort,
  input  logic                               vec_valid,
  output logic                               vec_ready,
  output logic [`LOG_ALLOWED_PRECISIONS-1:0] data_type,
  output logic [1:0]                         enable_fp_unit,
  output logic                               test_mode,
  output logic                               enable,
  output logic                               enable_in_ff,
  output logic                               enable_chain,
  output logic                               enable_out_ff,
  output logic                               y_valid,
`ifdef MXU_SEQ_PERF_CNT_EN
  output logic [31:0]                        busy_cycles,
  output logic [31:0]                        stall_cycles,
`endif
  output logic                               done
);
  localparam int L = M + K - 1;
  localparam int FW = $clog2(L + 1);
  localparam int HW = $clog2(L + 2);
  localparam logic [FW-1:0] FL_LAST = FW'(L - 1);
  localparam logic [HW-1:0] H_SAT = HW'(L + 1);
  typedef enum logic [2:0] {IDLE, SETUP, STREAM, FLUSH, DRAIN, DONE} state_t;
  state_t st, nxt;
  logic [CW-1:0] n_vec, in_cnt;
  logic [FW-1:0] fl_cnt;
  logic [HW-1:0] ch_cnt;
  logic go, kill, last_vec;
  assign go = ready & start;
  assign kill = abort & (st != IDLE);
  assign last_vec = vec_valid & (in_cnt + 1'b1 == n_vec);
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = !start ? IDLE : (cfg_n_vectors == '0) ? DONE : SETUP;
      SETUP:   nxt = STREAM;
      STREAM:  nxt = last_vec ? FLUSH : STREAM;
      FLUSH:   nxt = (fl_cnt == FL_LAST) ? DRAIN : FLUSH;
      DRAIN:   nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end
  always_comb begin
    ready = st == IDLE;
    enable = (st == SETUP) | (st == STREAM) | (st == FLUSH) | (st == DRAIN);
    enable_in_ff = (st == SETUP) | (st == STREAM);
    enable_chain = (st == FLUSH) | ((st == STREAM) & vec_valid);
    vec_ready = (st == STREAM) & vec_valid;
    enable_out_ff = st == DRAIN;
    done = st == DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) {data_type, enable_fp_unit, test_mode, n_vec} <= '0;
    else if (go) {data_type, enable_fp_unit, test_mode, n_vec} <= {cfg_data_type, cfg_fp_unit, cfg_test_mode, cfg_n_vectors};
  // ch_cnt saturates once the first vector's result has reached the array output
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_cnt <= '0;
      fl_cnt <= '0;
      ch_cnt <= '0;
      y_valid <= 1'b0;
    end else begin
      in_cnt <= (kill || st != STREAM) ? '0 : in_cnt + CW'(vec_valid);
      fl_cnt <= (kill || st != FLUSH) ? '0 : fl_cnt + 1'b1;
      ch_cnt <= (kill || st == IDLE) ? '0 : ch_cnt + HW'(enable_chain && ch_cnt != H_SAT);
      y_valid <= !kill && (enable_out_ff || (enable_chain && ch_cnt == H_SAT));
    end
`ifdef MXU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy_cycles <= '0;
      stall_cycles <= '0;
    end else if (go) begin
      busy_cycles <= '0;
      stall_cycles <= '0;
    end else begin
      if (st != IDLE && ~&busy_cycles) busy_cycles <= busy_cycles + 1'b1;
      if (st == STREAM && !vec_valid && ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
    end
`endif
endmodule

// File: doc/mxu_sequencer.md
Name: mxu_sequencer

Overview:
- Cycle-level controller that drives one mxu_wrapper instance (M×K systolic array) through one matrix-vector job.
- Accepts a start/config handshake from the host-side control path and latches data_type, FP-unit select and vector count.
- Sequences enable, enable_in_ff, enable_chain and enable_out_ff over load / compute / drain phases, then pulses done.
- Sits between the AXI-lite config block and mxu_wrapper; the only owner of the MXU enables.

Parameters:
- M, 4, array rows (output vector length).
- K, 4, array columns (input vector length).
- MAX_VECTORS, 256, maximum input vectors per job; counter width is $clog2(MAX_VECTORS+1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only when ready=1.
- ready  out  1  high in IDLE only.
- cfg_data_type  in  `LOG_ALLOWED_PRECISIONS  precision code, latched on start.
- cfg_fp_unit  in  2  FP unit select, latched on start.
- cfg_n_vectors  in  $clog2(MAX_VECTORS+1)  vectors to stream; 0 means an empty job.
- cfg_test_mode  in  1  test_mode value, latched on start.
- abort  in  1  synchronous job cancel.
- vec_valid  in  1  upstream has an input vector on input_data.
- vec_ready  out  1  vector consumed this cycle.
- data_type  out  `LOG_ALLOWED_PRECISIONS  to mxu_wrapper.
- enable_fp_unit  out  2  to mxu_wrapper.
- test_mode  out  1  to mxu_wrapper.
- enable  out  1  to mxu_wrapper.
- enable_in_ff  out  1  to mxu_wrapper.
- enable_chain  out  1  to mxu_wrapper.
- enable_out_ff  out  1  to mxu_wrapper.
- y_valid  out  1  y of mxu_wrapper holds a result this cycle.
- done  out  1  one-cycle pulse at end of job.

Behaviour:
- Reset values: ready=1; every other output 0; data_type=0; enable_fp_unit=0; FSM in IDLE; counters 0.
- Latency constant: L = M+K-1 (array fill/flush depth).
- IDLE
  - ready=1.
  - start=1 latches all cfg_* inputs into registers that drive data_type, enable_fp_unit and test_mode.
  - Next state: DONE if cfg_n_vectors=0, else SETUP.
- SETUP (1 cycle)
  - enable=1, enable_in_ff=1, all other enables 0.
  - Precision settles before data moves.
  - Next state: STREAM.
- STREAM
  - enable=1, enable_in_ff=1.
  - vec_ready = vec_valid (no skid).
  - enable_chain=1 only in cycles where vec_valid=1; a vec_valid=0 cycle stalls the chain and holds in_cnt.
  - in_cnt increments per accepted vector.
  - When in_cnt reaches n_vectors-1 and is accepted, go to FLUSH.
- FLUSH
  - enable_chain=1 for exactly L cycles, no vec_ready.
- DRAIN_OUT
  - enable_out_ff=1 for 1 cycle.
  - Next state: DONE.
- y_valid: asserted 1 cycle after enable_out_ff and also for every output shift during STREAM/FLUSH once L chain cycles have elapsed since the first accepted vector. Total y_valid pulses per job = n_vectors.
- DONE
  - done=1 for 1 cycle; all enables 0.
  - Next state: IDLE.
- Config registers hold their values through IDLE until the next start.
- start while ready=0 is ignored.
- abort in any non-IDLE state:
  - next cycle goes to IDLE with all enables 0.
  - done is not pulsed.
  - counters are cleared.
  - abort in IDLE has no effect.
  - abort has priority over every other transition.
- Asynchronous reset mid-job: immediate return to reset values, no done.
- n_vectors=MAX_VECTORS must complete with no counter overflow.

Optional Feature:
- Macro: MXU_SEQ_PERF_CNT_EN.
- When defined:
  - adds outputs busy_cycles[31:0] and stall_cycles[31:0].
  - busy_cycles counts every non-IDLE cycle; stall_cycles counts STREAM cycles with vec_valid=0.
  - Both clear on accepted start, saturate at 2^32-1 and hold after done.
  - Both clear on reset.
- When undefined: these ports and the counters do not exist.

Test Plan:
- Reset then idle, M=K=3: ready=1, all enables 0, done never pulses over 20 cycles.
- INT8 job, n_vectors=3, vec_valid held 1, M=K=3 (L=5):
  - SETUP 1 cycle, STREAM 3 cycles, FLUSH 5 cycles, DRAIN_OUT 1 cycle.
  - done exactly 11 cycles after the start cycle.
  - 3 y_valid pulses; data_type holds INT8 throughout.
- Same job with vec_valid=0 in every other STREAM cycle: enable_chain low in those cycles, done 2 cycles later than the previous case, 3 y_valid pulses.
- cfg_n_vectors=0: SETUP skipped, done pulses the cycle after start, no enable asserted.
- abort in the 2nd FLUSH cycle: next cycle IDLE, enables 0, no done; a following start runs normally.
- Async reset low mid-STREAM: outputs at reset values within the same cycle. With MXU_SEQ_PERF_CNT_EN defined, busy_cycles=11 after the clean 3-vector job.
